// File: rtl/control_pkg.sv
// Shared encodings for the CPU control unit: opcodes, ALU functions,
// register-index selects and the registered control bundle.
package control_pkg;

    typedef enum logic [3:0] {
        OP_SUB  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_NEG  = 4'b0011,
        OP_BEQ  = 4'b0100,
        OP_BGT  = 4'b0101,
        OP_BLT  = 4'b0110,
        OP_B    = 4'b0111,
        OP_LDR  = 4'b1000,
        OP_STR  = 4'b1001,
        OP_MOVI = 4'b1010,
        OP_AND  = 4'b1011,
        OP_OR   = 4'b1100,
        OP_ADDI = 4'b1101,
        OP_LDRD = 4'b1110,
        OP_NOP  = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_MUL   = 3'b010,
        ALU_NEG   = 3'b011,
        ALU_AND   = 3'b100,
        ALU_OR    = 3'b101,
        ALU_PASSB = 3'b110,
        ALU_NONE  = 3'b111
    } alu_op_e;

    localparam logic [1:0] RI_RD_RS_RT = 2'b00;
    localparam logic [1:0] RI_RD_RS    = 2'b01;
    localparam logic [1:0] RI_NONE     = 2'b10;

    typedef struct packed {
        logic       wbs;
        logic       wme;
        logic       mm;
        alu_op_e    alu_op;
        logic [1:0] ri;
        logic       wre;
        logic       wm;
        logic       am;
        logic       ni;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = '{
        wbs: 1'b0, wme: 1'b0, mm: 1'b0, alu_op: ALU_ADD, ri: RI_RD_RS_RT,
        wre: 1'b0, wm: 1'b0, am: 1'b0, ni: 1'b0
    };

endpackage

// File: rtl/control_unit_if.sv
// Decode request (opcode, flags, pipeline control) and registered control outputs.
interface control_unit_if;
    logic [3:0] opCode;
    logic       flagN;
    logic       flagZ;
    logic       stall;
    logic       flush;
    logic       wbs;
    logic       wme;
    logic       mm;
    logic [2:0] ALUop;
    logic [1:0] ri;
    logic       wre;
    logic       wm;
    logic       am;
    logic       ni;

    modport master (
        output opCode, flagN, flagZ, stall, flush,
        input  wbs, wme, mm, ALUop, ri, wre, wm, am, ni
    );

    modport slave (
        input  opCode, flagN, flagZ, stall, flush,
        output wbs, wme, mm, ALUop, ri, wre, wm, am, ni
    );
endinterface

// File: rtl/control_decode.sv
// Combinational opcode/flag decode into the control bundle.
// Latency: none. Backpressure: none, pure function of its inputs.
// Unlisted or unknown opcodes fall through to the NOP bundle.
module control_decode
    import control_pkg::*;
(
    input  logic [3:0] opCode,
    input  logic       flagN,
    input  logic       flagZ,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = NOP_CTRL;
        case (opCode)
            OP_SUB:  begin ctrl.alu_op = ALU_SUB; ctrl.wre = 1'b1; end
            OP_ADD:  begin ctrl.alu_op = ALU_ADD; ctrl.wre = 1'b1; end
            OP_MUL:  begin ctrl.alu_op = ALU_MUL; ctrl.wre = 1'b1; end
            OP_NEG:  begin
                ctrl.alu_op = ALU_NEG;
                ctrl.ri     = RI_RD_RS;
                ctrl.wre    = 1'b1;
            end
            // Branches only steer the PC; flags matter nowhere else.
            OP_BEQ, OP_BGT, OP_BLT, OP_B: begin
                ctrl.alu_op = ALU_NONE;
                ctrl.ri     = RI_NONE;
                case (opCode)
                    OP_BEQ:  ctrl.ni = flagZ;
                    OP_BGT:  ctrl.ni = ~flagN & ~flagZ;
                    OP_BLT:  ctrl.ni = flagN;
                    default: ctrl.ni = 1'b1;
                endcase
            end
            OP_LDR:  begin
                ctrl.wbs = 1'b1;
                ctrl.ri  = RI_RD_RS;
                ctrl.wre = 1'b1;
                ctrl.wm  = 1'b1;
                ctrl.am  = 1'b1;
            end
            OP_STR:  begin ctrl.wme = 1'b1; ctrl.am = 1'b1; end
            OP_MOVI: begin
                ctrl.alu_op = ALU_PASSB;
                ctrl.ri     = RI_NONE;
                ctrl.wre    = 1'b1;
                ctrl.am     = 1'b1;
            end
            OP_AND:  begin ctrl.alu_op = ALU_AND; ctrl.wre = 1'b1; end
            OP_OR:   begin ctrl.alu_op = ALU_OR;  ctrl.wre = 1'b1; end
            OP_ADDI: begin
                ctrl.ri  = RI_RD_RS;
                ctrl.wre = 1'b1;
                ctrl.am  = 1'b1;
            end
            // Load with the register operand used directly as the address.
            OP_LDRD: begin
                ctrl.wbs = 1'b1;
                ctrl.mm  = 1'b1;
                ctrl.ri  = RI_RD_RS;
                ctrl.wre = 1'b1;
                ctrl.wm  = 1'b1;
            end
            default: ctrl = NOP_CTRL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Instruction decode with the decode/execute control register.
// Latency: 1 cycle from opcode/flags to outputs.
// Backpressure: stall holds the register, flush loads NOP and overrides stall.
module control_unit
    import control_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    control_unit_if.slave        bus
);

    ctrl_t ctrl_next;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .opCode (bus.opCode),
        .flagN  (bus.flagN),
        .flagZ  (bus.flagZ),
        .ctrl   (ctrl_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= NOP_CTRL;
        end else if (bus.flush) begin
            ctrl_q <= NOP_CTRL;
        end else if (!bus.stall) begin
            ctrl_q <= ctrl_next;
        end
    end

    assign bus.wbs   = ctrl_q.wbs;
    assign bus.wme   = ctrl_q.wme;
    assign bus.mm    = ctrl_q.mm;
    assign bus.ALUop = ctrl_q.alu_op;
    assign bus.ri    = ctrl_q.ri;
    assign bus.wre   = ctrl_q.wre;
    assign bus.wm    = ctrl_q.wm;
    assign bus.am    = ctrl_q.am;
    assign bus.ni    = ctrl_q.ni;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: table-driven reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   armed  = 1'b0;

    control_unit_if bus();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Bundle order: wbs wme mm ALUop[2:0] ri[1:0] wre wm am ni
    wire [11:0] dut_vec = {bus.wbs, bus.wme, bus.mm, bus.ALUop, bus.ri,
                           bus.wre, bus.wm, bus.am, bus.ni};

    // Decode table rows without ni: wbs wme mm ALUop ri wre wm am
    logic [10:0] tbl [16];
    initial begin
        tbl[0]  = 11'b0_0_0_001_00_1_0_0;
        tbl[1]  = 11'b0_0_0_000_00_1_0_0;
        tbl[2]  = 11'b0_0_0_010_00_1_0_0;
        tbl[3]  = 11'b0_0_0_011_01_1_0_0;
        tbl[4]  = 11'b0_0_0_111_10_0_0_0;
        tbl[5]  = 11'b0_0_0_111_10_0_0_0;
        tbl[6]  = 11'b0_0_0_111_10_0_0_0;
        tbl[7]  = 11'b0_0_0_111_10_0_0_0;
        tbl[8]  = 11'b1_0_0_000_01_1_1_1;
        tbl[9]  = 11'b0_1_0_000_00_0_0_1;
        tbl[10] = 11'b0_0_0_110_10_1_0_1;
        tbl[11] = 11'b0_0_0_100_00_1_0_0;
        tbl[12] = 11'b0_0_0_101_00_1_0_0;
        tbl[13] = 11'b0_0_0_000_01_1_0_1;
        tbl[14] = 11'b1_0_1_000_01_1_1_0;
        tbl[15] = 11'b0_0_0_000_00_0_0_0;
    end

    function automatic logic [11:0] model(input logic [3:0] op, input logic n, input logic z);
        logic taken;
        taken = 1'b0;
        if (op == 4'd4) taken = z;
        if (op == 4'd5) taken = !n && !z;
        if (op == 4'd6) taken = n;
        if (op == 4'd7) taken = 1'b1;
        return {tbl[op], taken};
    endfunction

    logic [11:0] exp_q = '0;
    always @(posedge clk or posedge rst) begin
        if (rst)
            exp_q <= '0;
        else if (bus.flush)
            exp_q <= '0;
        else if (!bus.stall)
            exp_q <= model(bus.opCode, bus.flagN, bus.flagZ);
    end

    always @(negedge clk) begin
        if (armed && !rst) begin
            checks++;
            if (dut_vec !== exp_q) begin
                errors++;
                $display("FAIL model_cycle t=%0t got=%b want=%b", $time, dut_vec, exp_q);
            end
            checks++;
            if ((bus.wme && bus.wre) || (bus.wm && !bus.wbs)) begin
                errors++;
                $display("FAIL invariant t=%0t got=%b want=no wme&wre, wm implies wbs", $time, dut_vec);
            end
        end
    end

    task automatic ck(input string name, input logic [11:0] act, input logic [11:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, act, want);
        end
    endtask

    task automatic apply(input logic [3:0] op, input logic n, input logic z,
                         input logic s, input logic f);
        bus.opCode = op;
        bus.flagN  = n;
        bus.flagZ  = z;
        bus.stall  = s;
        bus.flush  = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.opCode = 4'hF;
        bus.flagN  = 1'b0;
        bus.flagZ  = 1'b0;
        bus.stall  = 1'b0;
        bus.flush  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        armed = 1'b1;
        ck("reset_state", dut_vec, 12'b0);

        apply(4'd0, 0, 0, 0, 0);
        ck("sub", dut_vec, 12'b0_0_0_001_00_1_0_0_0);
        #1 rst = 1'b1;
        #1 ck("async_reset", dut_vec, 12'b0);
        #1 rst = 1'b0;

        apply(4'd0, 0, 0, 0, 0);
        ck("sub_again", dut_vec, 12'b0_0_0_001_00_1_0_0_0);
        apply(4'd3, 0, 0, 0, 0);
        ck("neg", dut_vec, 12'b0_0_0_011_01_1_0_0_0);

        apply(4'd4, 0, 1, 0, 0); ck("beq_z1",    dut_vec, 12'b0_0_0_111_10_0_0_0_1);
        apply(4'd4, 0, 0, 0, 0); ck("beq_z0",    dut_vec, 12'b0_0_0_111_10_0_0_0_0);
        apply(4'd5, 1, 0, 0, 0); ck("bgt_n1z0",  dut_vec, 12'b0_0_0_111_10_0_0_0_0);
        apply(4'd5, 0, 0, 0, 0); ck("bgt_n0z0",  dut_vec, 12'b0_0_0_111_10_0_0_0_1);
        apply(4'd5, 0, 1, 0, 0); ck("bgt_n0z1",  dut_vec, 12'b0_0_0_111_10_0_0_0_0);
        apply(4'd6, 0, 0, 0, 0); ck("blt_n0",    dut_vec, 12'b0_0_0_111_10_0_0_0_0);
        apply(4'd6, 1, 0, 0, 0); ck("blt_n1",    dut_vec, 12'b0_0_0_111_10_0_0_0_1);
        apply(4'd7, 1, 1, 0, 0); ck("b_uncond",  dut_vec, 12'b0_0_0_111_10_0_0_0_1);
        apply(4'd8, 1, 1, 0, 0); ck("ldr",       dut_vec, 12'b1_0_0_000_01_1_1_1_0);
        apply(4'd14, 0, 0, 0, 0); ck("ldrd",     dut_vec, 12'b1_0_1_000_01_1_1_0_0);
        apply(4'd10, 0, 1, 0, 0); ck("movi",     dut_vec, 12'b0_0_0_110_10_1_0_1_0);
        apply(4'd9, 0, 0, 0, 0); ck("str",       dut_vec, 12'b0_1_0_000_00_0_0_1_0);
        apply(4'd2, 0, 0, 1, 0); ck("stall_1",   dut_vec, 12'b0_1_0_000_00_0_0_1_0);
        apply(4'd7, 1, 1, 1, 0); ck("stall_2",   dut_vec, 12'b0_1_0_000_00_0_0_1_0);
        apply(4'd0, 0, 0, 1, 1); ck("flush_over_stall", dut_vec, 12'b0);
        apply(4'd12, 0, 0, 0, 0); ck("or",       dut_vec, 12'b0_0_0_101_00_1_0_0_0);
        apply(4'd15, 1, 0, 0, 0); ck("nop",      dut_vec, 12'b0);

        // Every opcode with every flag combination, checked by the model process.
        for (int op = 0; op < 16; op++) begin
            for (int fl = 0; fl < 4; fl++) begin
                apply(4'(op), fl[1], fl[0], 1'b0, 1'b0);
            end
        end

        for (int i = 0; i < 300; i++) begin
            apply(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end

        @(negedge clk);
        armed = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
